// File: rtl/fetch_pkg.sv
// Shared types and constants for the PC fetch sequencer.
package fetch_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        HOLD    = 2'd2,
        DISCARD = 2'd3
    } fetch_state_t;

    localparam logic [31:0] PC_INC    = 32'd4;
    localparam logic [31:0] NOP_INSTR = 32'h0;

endpackage

// File: rtl/fetch_out_reg.sv
// Instruction/PC/valid register presented to decode; clear wins over load.
module fetch_out_reg (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_load,
    input  logic        i_clear,
    input  logic [31:0] i_instr,
    input  logic [31:0] i_pc,
    output logic [31:0] o_instr,
    output logic [31:0] o_instr_pc,
    output logic        o_valid
);
    import fetch_pkg::*;

    logic [31:0] r_instr;
    logic [31:0] r_instr_pc;
    logic        r_valid;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_instr    <= NOP_INSTR;
            r_instr_pc <= 32'h0;
            r_valid    <= 1'b0;
        end else if (i_clear) begin
            r_valid    <= 1'b0;
        end else if (i_load) begin
            r_instr    <= i_instr;
            r_instr_pc <= i_pc;
            r_valid    <= 1'b1;
        end
    end

    assign o_instr    = r_instr;
    assign o_instr_pc = r_instr_pc;
    assign o_valid    = r_valid;

endmodule

// File: rtl/pc_fetch_sequencer.sv
// Architectural PC owner and req/ack instruction fetch FSM with redirect discard.
// Optional macro FETCH_MISALIGN_TRAP_EN adds oMisalign and blocks fetches from unaligned PCs.
module pc_fetch_sequencer
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        iClk,
    input  logic        iReset_n,
    input  logic [31:0] iNewPC,
    input  logic        iRedirect,
    input  logic        iStall,
    output logic [31:0] oNextPC,
    output logic [31:0] oPC,
    output logic        oIMemReq,
    output logic [31:0] oIMemAddr,
    input  logic        iIMemAck,
    input  logic [31:0] iIMemData,
    output logic [31:0] oInstr,
    output logic [31:0] oInstrPC,
    output logic        oInstrValid
`ifdef FETCH_MISALIGN_TRAP_EN
    ,
    output logic        oMisalign
`endif
);

    fetch_state_t r_state;
    fetch_state_t w_state_nxt;
    logic [31:0]  r_pc;
    logic [31:0]  w_pc_nxt;
    logic [31:0]  r_stale_addr;
    logic [31:0]  w_fetch_addr;
    logic         w_load;
    logic         w_clear;
    logic         w_mis_wait;

`ifdef FETCH_MISALIGN_TRAP_EN
    logic r_mis_wait;
    logic r_misalign;
    logic w_entry;

    assign w_mis_wait = r_mis_wait;
    assign oMisalign  = r_misalign;
    // A fresh arrival in REQ: anything except sitting in the trap wait without a redirect.
    assign w_entry    = (w_state_nxt == REQ) &&
                        !((r_state == REQ) && r_mis_wait && !iRedirect);
`else
    assign w_mis_wait = 1'b0;
`endif

    assign w_fetch_addr = {r_pc[31:2], 2'b00};
    assign oPC          = r_pc;
    assign oNextPC      = r_pc + PC_INC;
    assign oIMemReq     = ((r_state == REQ) && !w_mis_wait) || (r_state == DISCARD);
    assign oIMemAddr    = (r_state == DISCARD) ? r_stale_addr : w_fetch_addr;

    always_comb begin
        w_state_nxt = r_state;
        w_pc_nxt    = r_pc;
        w_load      = 1'b0;
        w_clear     = 1'b0;
        if (iRedirect) begin
            w_pc_nxt = iNewPC;
            w_clear  = 1'b1;
        end
        case (r_state)
            IDLE: w_state_nxt = REQ;
            REQ: begin
                if (iRedirect) begin
                    // Without an ack the issued fetch is still in flight and must be drained.
                    w_state_nxt = (iIMemAck || w_mis_wait) ? REQ : DISCARD;
                end else if (w_mis_wait) begin
                    if (!iStall) w_clear = 1'b1;
                end else if (iIMemAck) begin
                    w_load      = 1'b1;
                    w_pc_nxt    = iNewPC;
                    w_state_nxt = iStall ? HOLD : REQ;
                end else if (!iStall) begin
                    w_clear = 1'b1;
                end
            end
            HOLD: begin
                if (iRedirect || !iStall) begin
                    w_state_nxt = REQ;
                    w_clear     = 1'b1;
                end
            end
            DISCARD: begin
                if (!iRedirect && iIMemAck) w_state_nxt = REQ;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge iClk or negedge iReset_n) begin
        if (!iReset_n) begin
            r_state      <= IDLE;
            r_pc         <= RESET_PC;
            r_stale_addr <= 32'h0;
`ifdef FETCH_MISALIGN_TRAP_EN
            r_mis_wait   <= 1'b0;
            r_misalign   <= 1'b0;
`endif
        end else begin
            r_state <= w_state_nxt;
            r_pc    <= w_pc_nxt;
            if ((r_state == REQ) && (w_state_nxt == DISCARD)) begin
                r_stale_addr <= w_fetch_addr;
            end
`ifdef FETCH_MISALIGN_TRAP_EN
            if (w_entry) begin
                r_mis_wait <= |w_pc_nxt[1:0];
                r_misalign <= |w_pc_nxt[1:0];
            end else begin
                r_misalign <= 1'b0;
                if (w_state_nxt != REQ) r_mis_wait <= 1'b0;
            end
`endif
        end
    end

    fetch_out_reg u_out_reg (
        .i_clk      (iClk),
        .i_rst_n    (iReset_n),
        .i_load     (w_load),
        .i_clear    (w_clear),
        .i_instr    (iIMemData),
        .i_pc       (r_pc),
        .o_instr    (oInstr),
        .o_instr_pc (oInstrPC),
        .o_valid    (oInstrValid)
    );

endmodule

// File: tb/tb_pc_fetch_sequencer.sv
// Directed vector bench for pc_fetch_sequencer (also covers FETCH_MISALIGN_TRAP_EN builds).
module tb_pc_fetch_sequencer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] new_pc;
    logic        redirect;
    logic        stall;
    logic        ack;
    logic [31:0] data;
    logic [31:0] next_pc;
    logic [31:0] pc;
    logic        req;
    logic [31:0] addr;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        valid;
`ifdef FETCH_MISALIGN_TRAP_EN
    logic        misalign;
`endif

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    pc_fetch_sequencer #(.RESET_PC(32'h0000_0000)) dut (
        .iClk        (clk),
        .iReset_n    (rst_n),
        .iNewPC      (new_pc),
        .iRedirect   (redirect),
        .iStall      (stall),
        .oNextPC     (next_pc),
        .oPC         (pc),
        .oIMemReq    (req),
        .oIMemAddr   (addr),
        .iIMemAck    (ack),
        .iIMemData   (data),
        .oInstr      (instr),
        .oInstrPC    (instr_pc),
        .oInstrValid (valid)
`ifdef FETCH_MISALIGN_TRAP_EN
        ,
        .oMisalign   (misalign)
`endif
    );

    typedef struct {
        logic [2:0]  ctl;        // {redirect, stall, ack} applied this cycle
        logic [31:0] newpc;
        logic [31:0] dat;
        logic        exp_req;
        logic [31:0] exp_addr;
        logic [31:0] exp_pc;
        logic        exp_valid;
        logic [31:0] exp_instr;
        logic [31:0] exp_ipc;
    } vec_t;

    vec_t vecs [21];

    localparam logic [31:0] D0 = 32'h1111_0000;
    localparam logic [31:0] D1 = 32'h1111_0004;
    localparam logic [31:0] D2 = 32'h2222_0100;
    localparam logic [31:0] D3 = 32'h3333_0200;
    localparam logic [31:0] D4 = 32'h4444_0204;
    localparam logic [31:0] D5 = 32'h5555_0500;
    localparam logic [31:0] D6 = 32'h6666_FFFC;
    localparam logic [31:0] D7 = 32'h7777_0102;

    function automatic vec_t mk(input logic [2:0] c, input logic [31:0] npc, input logic [31:0] d,
                                input logic rq, input logic [31:0] ad, input logic [31:0] p,
                                input logic v, input logic [31:0] ins, input logic [31:0] ipc);
        vec_t r;
        r.ctl = c; r.newpc = npc; r.dat = d; r.exp_req = rq; r.exp_addr = ad;
        r.exp_pc = p; r.exp_valid = v; r.exp_instr = ins; r.exp_ipc = ipc;
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [2:0] c, input logic [31:0] npc, input logic [31:0] d);
        redirect = c[2];
        stall    = c[1];
        ack      = c[0];
        new_pc   = npc;
        data     = d;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reset_values(input string tag);
        chk({tag, "_req"},    {31'b0, req},   32'h0);
        chk({tag, "_pc"},     pc,             32'h0);
        chk({tag, "_nextpc"}, next_pc,        32'h4);
        chk({tag, "_instr"},  instr,          32'h0);
        chk({tag, "_ipc"},    instr_pc,       32'h0);
        chk({tag, "_valid"},  {31'b0, valid}, 32'h0);
`ifdef FETCH_MISALIGN_TRAP_EN
        chk({tag, "_mis"},    {31'b0, misalign}, 32'h0);
`endif
    endtask

    initial begin
        //        ctl     newpc          data          req   addr           pc             v     instr ipc
        vecs[0]  = mk(3'b000, 32'h0,         32'h0,        1'b0, 32'h0,         32'h0,         1'b0, 32'h0, 32'h0);
        vecs[1]  = mk(3'b001, 32'h4,         D0,           1'b1, 32'h0,         32'h0,         1'b0, 32'h0, 32'h0);
        vecs[2]  = mk(3'b001, 32'h8,         D1,           1'b1, 32'h4,         32'h4,         1'b1, D0,    32'h0);
        vecs[3]  = mk(3'b100, 32'h100,       32'h0,        1'b1, 32'h8,         32'h8,         1'b1, D1,    32'h4);
        vecs[4]  = mk(3'b000, 32'h0,         32'h0,        1'b1, 32'h8,         32'h100,       1'b0, 32'h0, 32'h0);
        vecs[5]  = mk(3'b001, 32'hDEAD_0000, 32'hBAD0_0008,1'b1, 32'h8,         32'h100,       1'b0, 32'h0, 32'h0);
        vecs[6]  = mk(3'b011, 32'h104,       D2,           1'b1, 32'h100,       32'h100,       1'b0, 32'h0, 32'h0);
        vecs[7]  = mk(3'b010, 32'h0,         32'h0,        1'b0, 32'h0,         32'h104,       1'b1, D2,    32'h100);
        vecs[8]  = mk(3'b010, 32'h0,         32'h0,        1'b0, 32'h0,         32'h104,       1'b1, D2,    32'h100);
        vecs[9]  = mk(3'b000, 32'h0,         32'h0,        1'b0, 32'h0,         32'h104,       1'b1, D2,    32'h100);
        vecs[10] = mk(3'b101, 32'h200,       32'hBAD0_0104,1'b1, 32'h104,       32'h104,       1'b0, 32'h0, 32'h0);
        vecs[11] = mk(3'b001, 32'h204,       D3,           1'b1, 32'h200,       32'h200,       1'b0, 32'h0, 32'h0);
        vecs[12] = mk(3'b011, 32'h208,       D4,           1'b1, 32'h204,       32'h204,       1'b1, D3,    32'h200);
        vecs[13] = mk(3'b110, 32'h300,       32'h0,        1'b0, 32'h0,         32'h208,       1'b1, D4,    32'h204);
        vecs[14] = mk(3'b100, 32'h400,       32'h0,        1'b1, 32'h300,       32'h300,       1'b0, 32'h0, 32'h0);
        vecs[15] = mk(3'b100, 32'h500,       32'h0,        1'b1, 32'h300,       32'h400,       1'b0, 32'h0, 32'h0);
        vecs[16] = mk(3'b001, 32'hDEAD_0000, 32'hBAD0_0300,1'b1, 32'h300,       32'h500,       1'b0, 32'h0, 32'h0);
        vecs[17] = mk(3'b000, 32'h0,         32'h0,        1'b1, 32'h500,       32'h500,       1'b0, 32'h0, 32'h0);
        vecs[18] = mk(3'b001, 32'hFFFF_FFFC, D5,           1'b1, 32'h500,       32'h500,       1'b0, 32'h0, 32'h0);
        vecs[19] = mk(3'b001, 32'h0,         D6,           1'b1, 32'hFFFF_FFFC, 32'hFFFF_FFFC, 1'b1, D5,    32'h500);
        vecs[20] = mk(3'b000, 32'h0,         32'h0,        1'b1, 32'h0,         32'h0,         1'b1, D6,    32'hFFFF_FFFC);

        rst_n = 1'b0;
        drive(3'b000, 32'h0, 32'h0);
        repeat (2) @(posedge clk);
        #1;
        chk_reset_values("reset");
        rst_n = 1'b1;

        for (int i = 0; i < 21; i++) begin
            logic [31:0] exp_next;
            exp_next = vecs[i].exp_pc + 32'd4;
            chk($sformatf("c%0d_req", i), {31'b0, req}, {31'b0, vecs[i].exp_req});
            if (vecs[i].exp_req) chk($sformatf("c%0d_addr", i), addr, vecs[i].exp_addr);
            chk($sformatf("c%0d_pc", i), pc, vecs[i].exp_pc);
            chk($sformatf("c%0d_nextpc", i), next_pc, exp_next);
            chk($sformatf("c%0d_valid", i), {31'b0, valid}, {31'b0, vecs[i].exp_valid});
            if (vecs[i].exp_valid) begin
                chk($sformatf("c%0d_instr", i), instr, vecs[i].exp_instr);
                chk($sformatf("c%0d_ipc", i), instr_pc, vecs[i].exp_ipc);
            end
            drive(vecs[i].ctl, vecs[i].newpc, vecs[i].dat);
            next_cycle();
        end

        // Instruction consumed with no new ack: valid drops.
        chk("consumed_valid", {31'b0, valid}, 32'h0);
        chk("consumed_addr", addr, 32'h0);

        // Redirect + same-cycle ack to an unaligned target.
        drive(3'b101, 32'h0000_0102, 32'hBAD0_0000);
        next_cycle();
        chk("mis_pc", pc, 32'h0000_0102);
        chk("mis_nextpc", next_pc, 32'h0000_0106);
        chk("mis_valid", {31'b0, valid}, 32'h0);
`ifdef FETCH_MISALIGN_TRAP_EN
        chk("mis_req", {31'b0, req}, 32'h0);
        chk("mis_pulse", {31'b0, misalign}, 32'h1);
        drive(3'b001, 32'hDEAD_0000, 32'hBAD0_0001);
        next_cycle();
        chk("mis_pulse_end", {31'b0, misalign}, 32'h0);
        chk("mis_wait_req", {31'b0, req}, 32'h0);
        chk("mis_wait_pc", pc, 32'h0000_0102);
        drive(3'b000, 32'h0, 32'h0);
        next_cycle();
        chk("mis_wait_req2", {31'b0, req}, 32'h0);
        drive(3'b100, 32'h0000_0200, 32'h0);
        next_cycle();
        chk("mis_resume_req", {31'b0, req}, 32'h1);
        chk("mis_resume_addr", addr, 32'h0000_0200);
        chk("mis_resume_pulse", {31'b0, misalign}, 32'h0);
        drive(3'b000, 32'h0, 32'h0);
`else
        chk("mis_req", {31'b0, req}, 32'h1);
        chk("mis_addr", addr, 32'h0000_0100);
        drive(3'b001, 32'h0000_0106, D7);
        next_cycle();
        chk("mis_instr", instr, D7);
        chk("mis_ipc", instr_pc, 32'h0000_0102);
        chk("mis_next_addr", addr, 32'h0000_0104);
        drive(3'b000, 32'h0, 32'h0);
`endif

        // Asynchronous reset in the middle of an outstanding request.
        chk("pre_areset_req", {31'b0, req}, 32'h1);
        #3;
        rst_n = 1'b0;
        #1;
        chk_reset_values("areset");
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("post_reset_idle_req", {31'b0, req}, 32'h0);
        next_cycle();
        chk("post_reset_req", {31'b0, req}, 32'h1);
        chk("post_reset_addr", addr, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
